// File: rtl/rr_packet_arbiter_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
package rr_packet_arbiter_pkg;

  // ARB: choose a new winner each beat; LOCKED: one owner holds the grant until its last beat.
  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Wrapped increment; written out explicitly so non-power-of-two counts wrap at n-1.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx == n - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_packet_arbiter_select.sv
// Combinational round-robin pick: lowest valid index at or above the pointer,
// falling back to the lowest valid index overall when none sit at or above it.
module rr_select
  import rr_packet_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_any_valid
);

  logic [NUM_REQ-1:0] w_masked;
  logic [IDX_W-1:0]   w_pick_masked;
  logic [IDX_W-1:0]   w_pick_all;

  // Build the pointer mask and find the lowest set index in both groups.
  always_comb begin
    w_masked      = '0;
    w_pick_masked = '0;
    w_pick_all    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i >= int'(i_ptr)) w_masked[i] = i_valid[i];
    end
    // Scan downward so the last hit is the lowest index.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_masked[i]) w_pick_masked = IDX_W'(i);
      if (i_valid[i])  w_pick_all    = IDX_W'(i);
    end
  end

  assign o_winner    = (|w_masked) ? w_pick_masked : w_pick_all;
  assign o_any_valid = |i_valid;

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin arbiter with packet lock: NUM_REQ valid/ready/last streams share
// one registered output stream that carries the source index with each beat.
module rr_packet_arbiter
  import rr_packet_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                                clk_i,
  input  logic                                arst_ni,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0]                  req_last_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic                                out_valid_o,
  output logic [DATA_WIDTH-1:0]               out_data_o,
  output logic                                out_last_o,
  output logic [IDX_W-1:0]                    out_index_o,
  input  logic                                out_ready_i,
  output logic                                locked_o
);

  arb_state_e              r_state;
  arb_state_e              w_state_nxt;
  logic [IDX_W-1:0]        r_ptr;
  logic [IDX_W-1:0]        w_ptr_nxt;
  logic [IDX_W-1:0]        r_owner;
  logic [IDX_W-1:0]        w_owner_nxt;

  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic                    r_out_last;
  logic [IDX_W-1:0]        r_out_index;

  logic [IDX_W-1:0]        w_winner;
  logic                    w_any_valid;
  logic                    w_slot_free;
  logic [NUM_REQ-1:0]      w_ready;
  logic                    w_accept;
  logic [IDX_W-1:0]        w_sel;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_select (
    .i_valid     (req_valid_i),
    .i_ptr       (r_ptr),
    .o_winner    (w_winner),
    .o_any_valid (w_any_valid)
  );

  // The output slot can take a beat when empty or when it drains this cycle.
  assign w_slot_free = !r_out_valid || out_ready_i;

  // Next-state, grant and pointer/owner updates; ready is only raised where a beat can be taken.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_ready     = '0;
    w_accept    = 1'b0;
    w_sel       = w_winner;
    unique case (r_state)
      ARB: begin
        w_sel = w_winner;
        if (w_slot_free && w_any_valid) begin
          w_ready[w_winner] = 1'b1;
          w_accept          = 1'b1;
          if (req_last_i[w_winner]) begin
            w_ptr_nxt = IDX_W'(next_idx(32'(w_winner), NUM_REQ));
          end else begin
            w_state_nxt = LOCKED;
            w_owner_nxt = w_winner;
          end
        end
      end
      LOCKED: begin
        w_sel = r_owner;
        if (w_slot_free && req_valid_i[r_owner]) begin
          w_ready[r_owner] = 1'b1;
          w_accept         = 1'b1;
          if (req_last_i[r_owner]) begin
            w_state_nxt = ARB;
            w_ptr_nxt   = IDX_W'(next_idx(32'(r_owner), NUM_REQ));
          end
        end
      end
      default: begin
        w_state_nxt = ARB;
      end
    endcase
  end

  // While reset is asserted no requester may see a grant.
  assign req_ready_o = arst_ni ? w_ready : '0;

  // FSM state, round-robin pointer and lock owner.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state <= ARB;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // Output register: capture replaces a draining beat; otherwise clear on drain, hold on stall.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_index <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= req_data_i[w_sel];
      r_out_last  <= req_last_i[w_sel];
      r_out_index <= w_sel;
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_last_o  = r_out_last;
  assign out_index_o = r_out_index;
  assign locked_o    = (r_state == LOCKED);

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed bench for rr_packet_arbiter: a 4-requester instance for most scenarios
// and a 3-requester instance for the non-power-of-two pointer wrap.
module tb_rr_packet_arbiter;

  logic              clk;
  logic              arst_n;

  logic [3:0]        a_valid;
  logic [3:0][31:0]  a_data;
  logic [3:0]        a_last;
  logic [3:0]        a_ready;
  logic              a_ovalid;
  logic [31:0]       a_odata;
  logic              a_olast;
  logic [1:0]        a_oidx;
  logic              a_ordy;
  logic              a_locked;

  logic [2:0]        b_valid;
  logic [2:0][31:0]  b_data;
  logic [2:0]        b_last;
  logic [2:0]        b_ready;
  logic              b_ovalid;
  logic [31:0]       b_odata;
  logic              b_olast;
  logic [1:0]        b_oidx;
  logic              b_ordy;
  logic              b_locked;

  int n_vec = 0;
  int n_err = 0;

  rr_packet_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32)) dut_a (
    .clk_i       (clk),
    .arst_ni     (arst_n),
    .req_valid_i (a_valid),
    .req_data_i  (a_data),
    .req_last_i  (a_last),
    .req_ready_o (a_ready),
    .out_valid_o (a_ovalid),
    .out_data_o  (a_odata),
    .out_last_o  (a_olast),
    .out_index_o (a_oidx),
    .out_ready_i (a_ordy),
    .locked_o    (a_locked)
  );

  rr_packet_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32)) dut_b (
    .clk_i       (clk),
    .arst_ni     (arst_n),
    .req_valid_i (b_valid),
    .req_data_i  (b_data),
    .req_last_i  (b_last),
    .req_ready_o (b_ready),
    .out_valid_o (b_ovalid),
    .out_data_o  (b_odata),
    .out_last_o  (b_olast),
    .out_index_o (b_oidx),
    .out_ready_i (b_ordy),
    .locked_o    (b_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    arst_n  = 1'b0;
    a_valid = 4'b1111;
    a_last  = 4'b1111;
    a_ordy  = 1'b1;
    tick();
    tick();
    if (a_ready !== 4'b0000) begin
      $display("FAIL reset_ready: got %b expected 0000", a_ready); n_err++;
    end
    n_vec++;
    if ({a_ovalid, a_olast, a_locked, a_oidx} !== 5'b0) begin
      $display("FAIL reset_ctrl: got v=%b l=%b lk=%b i=%0d expected all 0", a_ovalid, a_olast, a_locked, a_oidx); n_err++;
    end
    n_vec++;
    if (a_odata !== 32'h0) begin
      $display("FAIL reset_data: got %h expected 00000000", a_odata); n_err++;
    end
    n_vec++;
    a_valid = 4'b0000;
    arst_n  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (a_ready !== 4'b0000) begin
        $display("FAIL idle_ready cyc %0d: got %b expected 0000", c, a_ready); n_err++;
      end
      n_vec++;
      tick();
      if (a_ovalid !== 1'b0 || a_locked !== 1'b0) begin
        $display("FAIL idle_out cyc %0d: got v=%b lk=%b expected 0 0", c, a_ovalid, a_locked); n_err++;
      end
      n_vec++;
    end
  endtask

  task automatic test_fair;
    int         exp_idx [5] = '{0, 1, 2, 3, 0};
    logic [3:0] er;
    for (int i = 0; i < 4; i++) a_data[i] = 32'h100 + i;
    a_last  = 4'b1111;
    a_valid = 4'b1111;
    a_ordy  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      er = 4'b0001 << exp_idx[k];
      if (a_ready !== er) begin
        $display("FAIL fair_ready beat %0d: got %b expected %b", k, a_ready, er); n_err++;
      end
      n_vec++;
      tick();
      if (a_ovalid !== 1'b1 || a_oidx !== 2'(exp_idx[k]) || a_odata !== 32'h100 + exp_idx[k]) begin
        $display("FAIL fair_out beat %0d: got v=%b i=%0d d=%h expected v=1 i=%0d d=%h",
                 k, a_ovalid, a_oidx, a_odata, exp_idx[k], 32'h100 + exp_idx[k]); n_err++;
      end
      n_vec++;
    end
    a_valid = 4'b0000;
    tick();
    if (a_ovalid !== 1'b0) begin
      $display("FAIL fair_drain: got v=%b expected 0", a_ovalid); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_lock;
    // ptr is 1 here: req1 wins over req0/req2 and sends a 3-beat packet.
    a_ordy  = 1'b1;
    a_valid = 4'b0111;
    a_last  = 4'b1101;
    a_data[0] = 32'hA0;
    a_data[1] = 32'hB1;
    a_data[2] = 32'hC0;
    #1;
    if (a_ready !== 4'b0010) begin
      $display("FAIL lock_ready1: got %b expected 0010", a_ready); n_err++;
    end
    n_vec++;
    tick();
    if (a_oidx !== 2'd1 || a_odata !== 32'hB1 || a_olast !== 1'b0 || a_locked !== 1'b1) begin
      $display("FAIL lock_beat1: got i=%0d d=%h l=%b lk=%b expected i=1 d=b1 l=0 lk=1", a_oidx, a_odata, a_olast, a_locked); n_err++;
    end
    n_vec++;
    // Owner goes idle: the others must stay stalled and the lock must hold.
    a_valid = 4'b0101;
    #1;
    if (a_ready !== 4'b0000) begin
      $display("FAIL lock_idle_ready: got %b expected 0000", a_ready); n_err++;
    end
    n_vec++;
    tick();
    if (a_ovalid !== 1'b0 || a_locked !== 1'b1) begin
      $display("FAIL lock_idle_out: got v=%b lk=%b expected v=0 lk=1", a_ovalid, a_locked); n_err++;
    end
    n_vec++;
    a_valid   = 4'b0111;
    a_data[1] = 32'hB2;
    #1;
    if (a_ready !== 4'b0010) begin
      $display("FAIL lock_ready2: got %b expected 0010", a_ready); n_err++;
    end
    n_vec++;
    tick();
    if (a_oidx !== 2'd1 || a_odata !== 32'hB2 || a_locked !== 1'b1) begin
      $display("FAIL lock_beat2: got i=%0d d=%h lk=%b expected i=1 d=b2 lk=1", a_oidx, a_odata, a_locked); n_err++;
    end
    n_vec++;
    a_data[1] = 32'hB3;
    a_last    = 4'b1111;
    tick();
    if (a_oidx !== 2'd1 || a_odata !== 32'hB3 || a_olast !== 1'b1 || a_locked !== 1'b0) begin
      $display("FAIL lock_beat3: got i=%0d d=%h l=%b lk=%b expected i=1 d=b3 l=1 lk=0", a_oidx, a_odata, a_olast, a_locked); n_err++;
    end
    n_vec++;
    a_valid = 4'b0101;
    #1;
    if (a_ready !== 4'b0100) begin
      $display("FAIL lock_next2_ready: got %b expected 0100", a_ready); n_err++;
    end
    n_vec++;
    tick();
    if (a_oidx !== 2'd2 || a_odata !== 32'hC0 || a_locked !== 1'b0) begin
      $display("FAIL lock_next2_out: got i=%0d d=%h lk=%b expected i=2 d=c0 lk=0", a_oidx, a_odata, a_locked); n_err++;
    end
    n_vec++;
    a_valid = 4'b0001;
    #1;
    if (a_ready !== 4'b0001) begin
      $display("FAIL lock_next0_ready: got %b expected 0001", a_ready); n_err++;
    end
    n_vec++;
    tick();
    if (a_oidx !== 2'd0 || a_odata !== 32'hA0) begin
      $display("FAIL lock_next0_out: got i=%0d d=%h expected i=0 d=a0", a_oidx, a_odata); n_err++;
    end
    n_vec++;
    a_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure;
    // ptr is 1 here.
    a_ordy    = 1'b0;
    a_valid   = 4'b0010;
    a_last    = 4'b1111;
    a_data[1] = 32'hDEADBEEF;
    #1;
    if (a_ready !== 4'b0010) begin
      $display("FAIL bp_first_ready: got %b expected 0010", a_ready); n_err++;
    end
    n_vec++;
    tick();
    a_data[1] = 32'hCAFEF00D;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (a_ready !== 4'b0000) begin
        $display("FAIL bp_stall_ready cyc %0d: got %b expected 0000", c, a_ready); n_err++;
      end
      n_vec++;
      if (a_ovalid !== 1'b1 || a_odata !== 32'hDEADBEEF || a_oidx !== 2'd1) begin
        $display("FAIL bp_hold cyc %0d: got v=%b d=%h i=%0d expected v=1 d=deadbeef i=1", c, a_ovalid, a_odata, a_oidx); n_err++;
      end
      n_vec++;
      tick();
    end
    a_ordy = 1'b1;
    #1;
    if (a_ready !== 4'b0010) begin
      $display("FAIL bp_release_ready: got %b expected 0010", a_ready); n_err++;
    end
    n_vec++;
    tick();
    if (a_ovalid !== 1'b1 || a_odata !== 32'hCAFEF00D) begin
      $display("FAIL bp_next_beat: got v=%b d=%h expected v=1 d=cafef00d", a_ovalid, a_odata); n_err++;
    end
    n_vec++;
    a_valid = 4'b0000;
    tick();
    if (a_ovalid !== 1'b0) begin
      $display("FAIL bp_drain: got v=%b expected 0", a_ovalid); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_wrap3;
    b_ordy = 1'b1;
    b_last = 3'b111;
    b_data[0] = 32'h30;
    b_data[1] = 32'h31;
    b_data[2] = 32'h32;
    b_valid = 3'b001;
    tick();
    b_valid = 3'b010;
    tick();
    b_valid = 3'b100;
    #1;
    if (b_ready !== 3'b100) begin
      $display("FAIL wrap_ready2: got %b expected 100", b_ready); n_err++;
    end
    n_vec++;
    tick();
    if (b_oidx !== 2'd2 || b_odata !== 32'h32 || b_olast !== 1'b1 || b_locked !== 1'b0) begin
      $display("FAIL wrap_out2: got i=%0d d=%h l=%b lk=%b expected i=2 d=32 l=1 lk=0", b_oidx, b_odata, b_olast, b_locked); n_err++;
    end
    n_vec++;
    b_valid = 3'b101;
    #1;
    if (b_ready !== 3'b001) begin
      $display("FAIL wrap_ready0: got %b expected 001", b_ready); n_err++;
    end
    n_vec++;
    tick();
    if (b_ovalid !== 1'b1 || b_oidx !== 2'd0 || b_odata !== 32'h30) begin
      $display("FAIL wrap_out0: got v=%b i=%0d d=%h expected v=1 i=0 d=30", b_ovalid, b_oidx, b_odata); n_err++;
    end
    n_vec++;
    b_valid = 3'b000;
    tick();
  endtask

  task automatic test_async_reset;
    // ptr is 2 here; req0 still wins because nothing valid sits at or above 2.
    a_ordy    = 1'b1;
    a_valid   = 4'b0001;
    a_last    = 4'b1110;
    a_data[0] = 32'hA1;
    tick();
    a_data[0] = 32'hA2;
    tick();
    if (a_locked !== 1'b1 || a_odata !== 32'hA2) begin
      $display("FAIL ar_pre: got lk=%b d=%h expected lk=1 d=a2", a_locked, a_odata); n_err++;
    end
    n_vec++;
    arst_n = 1'b0;
    #1;
    if (a_ovalid !== 1'b0 || a_locked !== 1'b0 || a_ready !== 4'b0000) begin
      $display("FAIL ar_immediate: got v=%b lk=%b rdy=%b expected 0 0 0000", a_ovalid, a_locked, a_ready); n_err++;
    end
    n_vec++;
    tick();
    a_last    = 4'b1111;
    a_data[2] = 32'hC2;
    a_valid   = 4'b0101;
    arst_n    = 1'b1;
    #1;
    // With the pointer back at 0, req0 outranks req2.
    if (a_ready !== 4'b0001) begin
      $display("FAIL ar_ptr_zero: got %b expected 0001", a_ready); n_err++;
    end
    n_vec++;
    a_valid = 4'b0100;
    #1;
    if (a_ready !== 4'b0100) begin
      $display("FAIL ar_ready2: got %b expected 0100", a_ready); n_err++;
    end
    n_vec++;
    tick();
    if (a_ovalid !== 1'b1 || a_oidx !== 2'd2 || a_odata !== 32'hC2 || a_locked !== 1'b0) begin
      $display("FAIL ar_winner2: got v=%b i=%0d d=%h lk=%b expected v=1 i=2 d=c2 lk=0", a_ovalid, a_oidx, a_odata, a_locked); n_err++;
    end
    n_vec++;
    a_valid = 4'b0000;
    tick();
  endtask

  initial begin
    arst_n  = 1'b0;
    a_valid = '0;
    a_data  = '0;
    a_last  = '0;
    a_ordy  = 1'b0;
    b_valid = '0;
    b_data  = '0;
    b_last  = '0;
    b_ordy  = 1'b1;
    test_reset();
    test_fair();
    test_lock();
    test_backpressure();
    test_wrap3();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
